// File: rtl/reg_dump_unit.sv
// Register-bank dump engine: freezes the CPU, then streams every register
// through one asynchronous read port on a valid/ready handshake.
module reg_dump_unit #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 16,
    parameter int AW      = 4,
    parameter int CYCLES  = 120,
    parameter int AUTO    = 1,
    parameter int CW      = 32,
    parameter int RELEASE = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic [AW-1:0]    o_rd_addr,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_cpu_halt,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [AW-1:0]    o_out_idx,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [CW-1:0]    o_cycles
);

    typedef enum logic [1:0] {
        S_COUNT,
        S_DRAIN,
        S_SEND,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [AW-1:0]  r_idx;
    logic           r_halt;

    logic           w_trig;
    logic           w_redump;
    logic           w_xfer;
    logic           w_last;

    // Auto trigger only lives in COUNT, so it can fire at most once per reset.
    assign w_trig   = (r_state == S_COUNT) &&
                      (i_start || ((AUTO != 0) && (r_cnt == CW'(CYCLES - 1))));
    assign w_redump = (r_state == S_DONE) && i_start;
    assign w_xfer   = (r_state == S_SEND) && i_out_ready;
    assign w_last   = (r_idx == AW'(NREGS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_COUNT: if (w_trig) w_next = S_DRAIN;
            S_DRAIN: w_next = S_SEND;
            S_SEND:  if (w_xfer && w_last) w_next = S_DONE;
            S_DONE:  if (i_start) w_next = S_DRAIN;
            default: w_next = S_COUNT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_COUNT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_COUNT) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_trig || w_redump) begin
                r_idx  <= '0;
                r_halt <= 1'b1;
            end else if (w_xfer) begin
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end else if (RELEASE != 0) begin
                    r_halt <= 1'b0;
                end
            end
        end
    end

    assign o_rd_addr   = r_idx;
    assign o_out_idx   = r_idx;
    assign o_out_data  = i_rd_data;
    assign o_cpu_halt  = r_halt;
    assign o_out_valid = (r_state == S_SEND);
    assign o_busy      = (r_state == S_DRAIN) || (r_state == S_SEND);
    assign o_done      = (r_state == S_DONE);
    assign o_cycles    = r_cnt;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: auto/start triggers, back-pressure,
// mid-dump reset, re-dump from DONE and a 32x32 configuration.
module tb_reg_dump_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] st;
    logic       ready;
    int         sel;
    int         total = 0;
    int         bad   = 0;

    logic [15:0] ra [16];
    logic [15:0] rb [16];
    logic [31:0] rc [32];

    logic [3:0]  a_addr, a_idx, b_addr, b_idx;
    logic [4:0]  c_addr, c_idx;
    logic [15:0] a_data, b_data, a_rd, b_rd;
    logic [31:0] c_data, c_rd;
    logic        a_halt, a_valid, a_busy, a_done;
    logic        b_halt, b_valid, b_busy, b_done;
    logic        c_halt, c_valid, c_busy, c_done;
    logic [31:0] a_cyc, b_cyc, c_cyc;

    assign a_rd = ra[a_addr];
    assign b_rd = rb[b_addr];
    assign c_rd = rc[c_addr];

    reg_dump_unit #(.WIDTH(16), .NREGS(16), .AW(4), .CYCLES(120), .AUTO(1), .CW(32), .RELEASE(0)) u_a (
        .i_clk(clk), .i_reset(rst[0]), .i_start(st[0]), .o_rd_addr(a_addr), .i_rd_data(a_rd),
        .o_cpu_halt(a_halt), .o_out_valid(a_valid), .i_out_ready(ready), .o_out_idx(a_idx),
        .o_out_data(a_data), .o_busy(a_busy), .o_done(a_done), .o_cycles(a_cyc));

    reg_dump_unit #(.WIDTH(16), .NREGS(16), .AW(4), .CYCLES(120), .AUTO(0), .CW(32), .RELEASE(0)) u_b (
        .i_clk(clk), .i_reset(rst[1]), .i_start(st[1]), .o_rd_addr(b_addr), .i_rd_data(b_rd),
        .o_cpu_halt(b_halt), .o_out_valid(b_valid), .i_out_ready(ready), .o_out_idx(b_idx),
        .o_out_data(b_data), .o_busy(b_busy), .o_done(b_done), .o_cycles(b_cyc));

    reg_dump_unit #(.WIDTH(32), .NREGS(32), .AW(5), .CYCLES(120), .AUTO(0), .CW(32), .RELEASE(0)) u_c (
        .i_clk(clk), .i_reset(rst[2]), .i_start(st[2]), .o_rd_addr(c_addr), .i_rd_data(c_rd),
        .o_cpu_halt(c_halt), .o_out_valid(c_valid), .i_out_ready(ready), .o_out_idx(c_idx),
        .o_out_data(c_data), .o_busy(c_busy), .o_done(c_done), .o_cycles(c_cyc));

    // View of whichever instance is currently under test
    logic        m_halt, m_valid, m_busy, m_done;
    logic [4:0]  m_idx;
    logic [31:0] m_data, m_cyc;

    always_comb begin
        m_halt = a_halt; m_valid = a_valid; m_busy = a_busy; m_done = a_done;
        m_idx = {1'b0, a_idx}; m_data = {16'h0, a_data}; m_cyc = a_cyc;
        if (sel == 1) begin
            m_halt = b_halt; m_valid = b_valid; m_busy = b_busy; m_done = b_done;
            m_idx = {1'b0, b_idx}; m_data = {16'h0, b_data}; m_cyc = b_cyc;
        end else if (sel == 2) begin
            m_halt = c_halt; m_valid = c_valid; m_busy = c_busy; m_done = c_done;
            m_idx = c_idx; m_data = c_data; m_cyc = c_cyc;
        end
    end

    function automatic logic [31:0] exp_data(input int s, input int i);
        if (s == 2) return 32'hDEAD0000 + 32'(i) * 32'h00010001;
        if (s == 1 && i == 5) return 32'h0000FFF6;
        return 32'(i * 3);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int s);
        rst[s] = 1'b1;
        tick_n(1);
        rst[s] = 1'b0;
    endtask

    task automatic pulse_start(input int s);
        st[s] = 1'b1;
        tick_n(1);
        st = '0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_valid"}, m_valid, 0);
        check_val({tag, "_halt"}, m_halt, 0);
        check_val({tag, "_busy"}, m_busy, 0);
        check_val({tag, "_done"}, m_done, 0);
        check_val({tag, "_idx"}, m_idx, 0);
        check_val({tag, "_cycles"}, m_cyc, 0);
    endtask

    // Consume one dump until done; optional stall at hold_at and start poke at start_at.
    task automatic drain(input int hold_at, input int hold_len, input int start_at,
                         output int nx, output int ncyc,
                         output logic [63:0] last_i, output logic [63:0] last_d);
        int  exp_i  = 0;
        int  held   = 0;
        int  budget = 400;
        bit  poked  = 0;
        nx = 0; ncyc = 0; last_i = 0; last_d = 0;
        while (m_done !== 1'b1 && budget > 0) begin
            ready = 1'b1;
            if (m_valid && int'(m_idx) == hold_at && held < hold_len) begin
                ready = 1'b0;
                held++;
                check_val("hold_data", m_data, exp_data(sel, hold_at));
            end
            if (m_valid) check_val("send_halt", m_halt, 1);
            if (m_valid && ready) begin
                check_val("word_idx", m_idx, exp_i);
                check_val("word_data", m_data, exp_data(sel, exp_i));
                last_i = 64'(m_idx);
                last_d = 64'(m_data);
                exp_i++;
                nx++;
            end
            if (m_valid && int'(m_idx) == start_at && !poked) begin
                st[sel] = 1'b1;
                poked = 1;
            end
            tick_n(1);
            st = '0;
            ncyc++;
            budget--;
        end
        if (m_done !== 1'b1) check_val("drain_timeout", 0, 1);
        ready = 1'b1;
    endtask

    int          nx, ncyc, guard;
    logic [63:0] li, ld;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ra[i] = 16'(i * 3);
            rb[i] = (i == 5) ? 16'hFFF6 : 16'(i * 3);
        end
        for (int i = 0; i < 32; i++) rc[i] = 32'hDEAD0000 + 32'(i) * 32'h00010001;
        rst = 3'b111; st = '0; ready = 1'b1; sel = 0;
        tick_n(2);
        rst = '0;

        // Auto trigger at cycle 120, 16 gapless words
        sel = 0;
        do_reset(0);
        check_idle("rst");
        tick_n(119);
        check_val("pre_trig_halt", m_halt, 0);
        check_val("pre_trig_cyc", m_cyc, 119);
        tick_n(1);
        check_val("trig_halt", m_halt, 1);
        check_val("drain_busy", m_busy, 1);
        check_val("drain_valid", m_valid, 0);
        check_val("trig_cyc", m_cyc, 120);
        tick_n(1);
        check_val("first_valid", m_valid, 1);
        check_val("first_idx", m_idx, 0);
        drain(-1, 0, -1, nx, ncyc, li, ld);
        check_val("auto_count", nx, 16);
        check_val("auto_cycles", ncyc, 16);
        check_val("done_busy", m_busy, 0);
        check_val("done_valid", m_valid, 0);
        check_val("done_halt", m_halt, 1);
        check_val("done_cyc", m_cyc, 120);

        // Re-dump from DONE; start during SEND must be ignored
        pulse_start(0);
        check_val("redump_done", m_done, 0);
        check_val("redump_busy", m_busy, 1);
        check_val("redump_halt", m_halt, 1);
        drain(-1, 0, 4, nx, ncyc, li, ld);
        check_val("redump_count", nx, 16);
        check_val("redump_cycles", ncyc, 17);
        check_val("redump_end_halt", m_halt, 1);

        // Back-pressure for 5 cycles at idx 7
        do_reset(0);
        tick_n(3);
        pulse_start(0);
        drain(7, 5, -1, nx, ncyc, li, ld);
        check_val("bp_count", nx, 16);
        check_val("bp_cycles", ncyc, 22);

        // Reset mid-SEND at idx 9, then a fresh auto dump
        do_reset(0);
        pulse_start(0);
        guard = 0;
        while (!(m_valid && m_idx == 9) && guard < 40) begin
            tick_n(1);
            guard++;
        end
        check_val("reach_idx9", m_idx, 9);
        rst[0] = 1'b1;
        tick_n(1);
        rst[0] = 1'b0;
        check_idle("midrst");
        tick_n(119);
        check_val("midrst_pre_halt", m_halt, 0);
        tick_n(1);
        check_val("midrst_trig_halt", m_halt, 1);
        drain(-1, 0, -1, nx, ncyc, li, ld);
        check_val("midrst_count", nx, 16);

        // Start-only instance: no auto trigger, start at cycle 10
        sel = 1;
        do_reset(1);
        tick_n(130);
        check_val("noauto_halt", m_halt, 0);
        check_val("noauto_busy", m_busy, 0);
        check_val("noauto_cyc", m_cyc, 130);
        do_reset(1);
        tick_n(9);
        pulse_start(1);
        check_val("start_halt", m_halt, 1);
        check_val("start_busy", m_busy, 1);
        check_val("start_cyc", m_cyc, 10);
        drain(-1, 0, -1, nx, ncyc, li, ld);
        check_val("start_count", nx, 16);
        tick_n(120);
        check_val("frozen_done", m_done, 1);
        check_val("frozen_cyc", m_cyc, 10);

        // 32 x 32-bit configuration
        sel = 2;
        do_reset(2);
        pulse_start(2);
        drain(-1, 0, -1, nx, ncyc, li, ld);
        check_val("wide_count", nx, 32);
        check_val("wide_last_idx", li, 31);
        check_val("wide_last_data", ld, 64'hDECC001F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Synthesizable register-bank dump engine; attaches beside the CPU datapath register file.
- Freezes the CPU, walks every register through one asynchronous read port, and streams each value out with a valid/ready handshake.
- Triggered after a programmed cycle count or by an external start pulse.
- Generalises the timed "wait N cycles, print all registers" check: register width, register count and trigger mode are parameters, and the dump is a hardware stream with back-pressure.

Parameters:
- WIDTH, 16, register data width in bits.
- NREGS, 16, number of registers dumped (indices 0..NREGS-1); must be >=2.
- AW, 4, register address width; must satisfy 2**AW >= NREGS.
- CYCLES, 120, cycles after reset before the automatic trigger; must be >=1.
- AUTO, 1, 1 enables the automatic trigger, 0 means start-only.
- CW, 32, width of the cycle counter.
- RELEASE, 0, 1 drops cpu_halt on entering DONE, 0 keeps the CPU frozen until reset or the next dump.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle dump request.
- rd_addr, out, AW, register file read address.
- rd_data, in, WIDTH, combinational register file read data for rd_addr.
- cpu_halt, out, 1, registered; freezes PC and register writes while 1.
- out_valid, out, 1, dump word valid.
- out_ready, in, 1, consumer accepts the word.
- out_idx, out, AW, index of the current word.
- out_data, out, WIDTH, value of the current word (equals rd_data).
- busy, out, 1, high in DRAIN and SEND.
- done, out, 1, high in DONE.
- cycles, out, CW, saturating count of COUNT-state cycles.

Behaviour:
- Reset (clk edge with reset=1):
  - state=COUNT; cnt=0; idx=0.
  - cpu_halt, out_valid, busy, done all 0.
  - rd_addr=0, out_idx=0.
  - reset dominates every other input, including mid-dump; a partial dump is abandoned and nothing further is emitted.
- COUNT:
  - cnt increments each cycle and saturates at all-ones; cycles=cnt.
  - Trigger = start OR (AUTO==1 AND cnt==CYCLES-1).
  - On trigger: next state DRAIN, cpu_halt<=1, idx<=0.
  - With CYCLES=120 and AUTO=1, cpu_halt rises on the edge ending the 120th cycle after reset deassert.
- DRAIN:
  - Exactly one cycle with cpu_halt=1 so the final in-flight register write lands.
  - busy=1, out_valid=0.
  - Always moves to SEND.
- SEND:
  - busy=1, out_valid=1, rd_addr=out_idx=idx, out_data=rd_data.
  - Handshake: a word transfers on an edge where out_valid&&out_ready.
  - If idx==NREGS-1, next state is DONE; otherwise idx<=idx+1.
  - While out_ready=0, idx and out_data hold stable (the CPU is frozen); out_valid never drops before transfer.
  - Exactly NREGS transfers per dump, in ascending index order, with no gaps when out_ready is held high: one word per cycle, first word the cycle after DRAIN.
- DONE:
  - done=1, busy=0, out_valid=0.
  - cpu_halt=0 if RELEASE==1; otherwise it stays 1.
  - cnt is frozen.
  - start in DONE moves to DRAIN with cpu_halt<=1 and idx<=0 (a re-dump); done drops on that edge.
- Ignored inputs:
  - start in DRAIN or SEND is ignored.
  - The auto trigger fires once per reset only; it is not re-evaluated after DONE.
- start and the auto condition asserted in the same COUNT cycle produce a single trigger.
- Output encoding: rd_addr and out_idx are driven with idx in all states (0 outside a dump after reset).

Test Plan:
- AUTO=1, CYCLES=120, regs preloaded R[i]=i*3, out_ready=1:
  - cpu_halt rises at cycle 120 and the first word appears at cycle 122.
  - 16 consecutive words (idx 0..15, data 0,3,...,45) are emitted.
  - done=1 at cycle 138; cycles=120.
- Back-pressure: out_ready=0 for 5 cycles at idx=7:
  - out_idx=7 and out_data=21 are held stable for those 5 cycles.
  - The total remains exactly 16 transfers, with no duplicates.
- AUTO=0, start pulse at cycle 10:
  - Dump begins at cycle 11.
  - No trigger occurs at cycle 120.
  - Negative value R5=16'hFFF6 is emitted as FFF6.
- Reset asserted at idx=9 mid-SEND:
  - Next cycle out_valid=0, cpu_halt=0, state COUNT, cnt=0.
  - A new auto dump starts from idx 0.
- RELEASE=0, start pulsed in DONE:
  - cpu_halt stays 1 throughout; a second full 16-word dump is emitted.
  - start pulsed during SEND has no effect.
- WIDTH=32, NREGS=32, AW=5:
  - 32 words are emitted.
  - The last word is at idx 31, with the full 32-bit value intact.
